// File: rtl/mips_multi_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// States, opcodes, funct codes, ALUOp, ALU control and srcB selects.
package mips_multi_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTE,
      S_ALUWB,
      S_ADDIEX,
      S_ADDIWB,
      S_BRANCH,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ALUOP_ADD = 2'b00,
      ALUOP_SUB = 2'b01,
      ALUOP_FN  = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       pc_src;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_reg;
      logic       reg_write;
      logic       srca;
      logic [1:0] srcb;
      logic       alu_en;
      aluop_t     aluop;
      logic       done;
   } ctrl_t;

   function automatic logic is_known_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
             (op == OP_ADDI) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational ALUOp/Funct to ALU control decoder.
// Unknown funct codes fall back to add.
module mips_alu_dec
   import mips_multi_pkg::*;
(
   input  aluop_t     i_aluop,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_ctrl
);

   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_aluop)
         ALUOP_SUB: o_alu_ctrl = ALU_SUB;
         ALUOP_FN: begin
            case (i_funct)
               FN_ADD:  o_alu_ctrl = ALU_ADD;
               FN_SUB:  o_alu_ctrl = ALU_SUB;
               FN_AND:  o_alu_ctrl = ALU_AND;
               FN_OR:   o_alu_ctrl = ALU_OR;
               FN_SLT:  o_alu_ctrl = ALU_SLT;
               default: o_alu_ctrl = ALU_ADD;
            endcase
         end
         default: o_alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS main control FSM with Moore-decoded strobes.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to halt on unknown opcodes.
module mips_multi_ctrl
   import mips_multi_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   output logic             PC_write,
   output logic             Branch,
   output logic             Pc_src_mux,
   output logic             lorD_mux,
   output logic             Mem_write,
   output logic             IR_write,
   output logic             Reg_Dst_mux,
   output logic             Mem_reg_mux,
   output logic             Reg_write,
   output logic             ALU_srcA_mux,
   output logic [1:0]       ALU_srcB_mux,
   output logic [2:0]       ALU_control,
   output logic             instr_done,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   output logic             illegal_o,
`endif
   output logic [CNT_W-1:0] instr_count
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;
   ctrl_t            w_ctrl;
   logic [2:0]       w_alu;

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH: w_next = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTE;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_BEQ:       w_next = S_BRANCH;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               default:      w_next = S_HALT;
`else
               default:      w_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:  w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   w_next = S_MEMWB;
         S_EXECUTE: w_next = S_ALUWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         S_HALT:    w_next = S_HALT;
         default:   w_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_ctrl = '0;
      case (r_state)
         S_FETCH: begin
            w_ctrl.pc_write = 1'b1;
            w_ctrl.ir_write = 1'b1;
            w_ctrl.srcb     = SRCB_FOUR;
            w_ctrl.alu_en   = 1'b1;
         end
         S_DECODE: begin
            w_ctrl.srcb   = SRCB_IMM_SH;
            w_ctrl.alu_en = 1'b1;
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
            w_ctrl.done   = !is_known_op(Op);
`endif
         end
         S_MEMADR, S_ADDIEX: begin
            w_ctrl.srca   = 1'b1;
            w_ctrl.srcb   = SRCB_IMM;
            w_ctrl.alu_en = 1'b1;
         end
         S_MEMRD: w_ctrl.iord = 1'b1;
         S_MEMWB: begin
            w_ctrl.mem_reg   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_ctrl.done      = 1'b1;
         end
         S_MEMWR: begin
            w_ctrl.iord      = 1'b1;
            w_ctrl.mem_write = 1'b1;
            w_ctrl.done      = 1'b1;
         end
         S_EXECUTE: begin
            w_ctrl.srca   = 1'b1;
            w_ctrl.srcb   = SRCB_REGB;
            w_ctrl.alu_en = 1'b1;
            w_ctrl.aluop  = ALUOP_FN;
         end
         S_ALUWB: begin
            w_ctrl.reg_dst   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_ctrl.done      = 1'b1;
         end
         S_ADDIWB: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.done      = 1'b1;
         end
         S_BRANCH: begin
            w_ctrl.srca   = 1'b1;
            w_ctrl.srcb   = SRCB_REGB;
            w_ctrl.alu_en = 1'b1;
            w_ctrl.aluop  = ALUOP_SUB;
            w_ctrl.branch = 1'b1;
            w_ctrl.pc_src = 1'b1;
            w_ctrl.done   = 1'b1;
         end
         default: w_ctrl = '0;
      endcase
      // Reset wins over the state decode so no strobe leaks in that cycle
      if (reset) w_ctrl = '0;
   end

   mips_alu_dec u_alu_dec (
      .i_aluop    (w_ctrl.aluop),
      .i_funct    (Funct),
      .o_alu_ctrl (w_alu)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_ctrl.done) r_count <= r_count + CNT_W'(1);
      end
   end

   assign PC_write     = w_ctrl.pc_write;
   assign Branch       = w_ctrl.branch;
   assign Pc_src_mux   = w_ctrl.pc_src;
   assign lorD_mux     = w_ctrl.iord;
   assign Mem_write    = w_ctrl.mem_write;
   assign IR_write     = w_ctrl.ir_write;
   assign Reg_Dst_mux  = w_ctrl.reg_dst;
   assign Mem_reg_mux  = w_ctrl.mem_reg;
   assign Reg_write    = w_ctrl.reg_write;
   assign ALU_srcA_mux = w_ctrl.srca;
   assign ALU_srcB_mux = w_ctrl.srcb;
   assign ALU_control  = w_ctrl.alu_en ? w_alu : 3'b000;
   assign instr_done   = w_ctrl.done;
   assign instr_count  = r_count;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   assign illegal_o    = !reset && (r_state == S_HALT);
`endif

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Scoreboard bench for mips_multi_ctrl: per-cycle expected strobes.
// Counter width 2 so the wrap is reached quickly.
module tb_mips_multi_ctrl;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    Op = 6'd0;
   logic [5:0]    Funct = 6'd0;
   logic          PC_write, Branch, Pc_src_mux, lorD_mux, Mem_write;
   logic          IR_write, Reg_Dst_mux, Mem_reg_mux, Reg_write;
   logic          ALU_srcA_mux;
   logic [1:0]    ALU_srcB_mux;
   logic [2:0]    ALU_control;
   logic          instr_done;
   logic [CW-1:0] instr_count;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic          illegal_o;
`endif

   always #5 clk = ~clk;

   mips_multi_ctrl #(.CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .Op           (Op),
      .Funct        (Funct),
      .PC_write     (PC_write),
      .Branch       (Branch),
      .Pc_src_mux   (Pc_src_mux),
      .lorD_mux     (lorD_mux),
      .Mem_write    (Mem_write),
      .IR_write     (IR_write),
      .Reg_Dst_mux  (Reg_Dst_mux),
      .Mem_reg_mux  (Mem_reg_mux),
      .Reg_write    (Reg_write),
      .ALU_srcA_mux (ALU_srcA_mux),
      .ALU_srcB_mux (ALU_srcB_mux),
      .ALU_control  (ALU_control),
      .instr_done   (instr_done),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      .illegal_o    (illegal_o),
`endif
      .instr_count  (instr_count)
   );

   typedef struct packed {
      logic       ill;
      logic       pcw;
      logic       br;
      logic       pcs;
      logic       iord;
      logic       memw;
      logic       irw;
      logic       rdst;
      logic       mreg;
      logic       rw;
      logic       sa;
      logic [1:0] sb;
      logic [2:0] alu;
      logic       done;
   } ov_t;

   typedef struct {
      string         st;
      ov_t           v;
      logic [CW-1:0] c;
   } exp_t;

   exp_t          sb[$];
   logic [CW-1:0] m_cnt = '0;
   int            n_chk = 0;
   int            n_fail = 0;

   function automatic logic [2:0] fn_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic ov_t exp_of(input string st, input logic [5:0] f);
      ov_t v = '0;
      if (st == "FETCH") begin
         v.pcw = 1; v.irw = 1; v.sb = 2'b01; v.alu = 3'b010;
      end else if (st == "DECODE" || st == "NOP_DECODE") begin
         v.sb = 2'b11; v.alu = 3'b010; v.done = (st == "NOP_DECODE");
      end else if (st == "MEMADR" || st == "ADDIEX") begin
         v.sa = 1; v.sb = 2'b10; v.alu = 3'b010;
      end else if (st == "MEMRD") begin
         v.iord = 1;
      end else if (st == "MEMWB") begin
         v.mreg = 1; v.rw = 1; v.done = 1;
      end else if (st == "MEMWR") begin
         v.iord = 1; v.memw = 1; v.done = 1;
      end else if (st == "EXECUTE") begin
         v.sa = 1; v.sb = 2'b00; v.alu = fn_alu(f);
      end else if (st == "ALUWB") begin
         v.rdst = 1; v.rw = 1; v.done = 1;
      end else if (st == "ADDIWB") begin
         v.rw = 1; v.done = 1;
      end else if (st == "BRANCH") begin
         v.sa = 1; v.sb = 2'b00; v.alu = 3'b110;
         v.br = 1; v.pcs = 1; v.done = 1;
      end else if (st == "HALT") begin
         v.ill = 1;
      end
      return v;
   endfunction

   task automatic push(input string st);
      exp_t e;
      e.st = st;
      e.v  = exp_of(st, Funct);
      e.c  = m_cnt;
      sb.push_back(e);
      if (e.v.done) m_cnt = m_cnt + 1'b1;
      if (st == "RESET") m_cnt = '0;
   endtask

   function automatic ov_t observe();
      ov_t o;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      o.ill = illegal_o;
`else
      o.ill = 1'b0;
`endif
      o.pcw = PC_write; o.br = Branch; o.pcs = Pc_src_mux;
      o.iord = lorD_mux; o.memw = Mem_write; o.irw = IR_write;
      o.rdst = Reg_Dst_mux; o.mreg = Mem_reg_mux; o.rw = Reg_write;
      o.sa = ALU_srcA_mux; o.sb = ALU_srcB_mux;
      o.alu = ALU_control; o.done = instr_done;
      return o;
   endfunction

   task automatic test_reset();
      exp_t e;
      push("RESET");
      push("RESET");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); reset = (e.st == "RESET"); #1;
         n_chk++;
         if (observe() !== e.v) begin
            n_fail++;
            $display("FAIL reset %s: got %h want %h", e.st, observe(), e.v);
         end
         n_chk++;
         if (instr_count !== e.c) begin
            n_fail++;
            $display("FAIL reset count: got %0d want %0d", instr_count, e.c);
         end
      end
   endtask

   task automatic test_lw();
      exp_t e;
      Op = 6'b100011;
      push("FETCH"); push("DECODE"); push("MEMADR");
      push("MEMRD"); push("MEMWB"); push("FETCH");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); reset = (e.st == "RESET"); #1;
         n_chk++;
         if (observe() !== e.v) begin
            n_fail++;
            $display("FAIL lw %s: got %h want %h", e.st, observe(), e.v);
         end
         n_chk++;
         if (instr_count !== e.c) begin
            n_fail++;
            $display("FAIL lw %s count: got %0d want %0d", e.st, instr_count, e.c);
         end
      end
   endtask

   task automatic test_sw_beq();
      exp_t e;
      Op = 6'b101011;
      push("DECODE"); push("MEMADR"); push("MEMWR");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); reset = (e.st == "RESET"); #1;
         if (e.st == "MEMWR") Op = 6'b000100;
         n_chk++;
         if (observe() !== e.v) begin
            n_fail++;
            $display("FAIL sw %s: got %h want %h", e.st, observe(), e.v);
         end
         n_chk++;
         if (instr_count !== e.c) begin
            n_fail++;
            $display("FAIL sw %s count: got %0d want %0d", e.st, instr_count, e.c);
         end
      end
      push("FETCH"); push("DECODE"); push("BRANCH"); push("FETCH");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); reset = (e.st == "RESET"); #1;
         n_chk++;
         if (observe() !== e.v) begin
            n_fail++;
            $display("FAIL beq %s: got %h want %h", e.st, observe(), e.v);
         end
         n_chk++;
         if (instr_count !== e.c) begin
            n_fail++;
            $display("FAIL beq %s count: got %0d want %0d", e.st, instr_count, e.c);
         end
      end
   endtask

   task automatic test_rtype();
      exp_t e;
      logic [5:0] fns [6];
      fns = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
      Op = 6'b000000;
      foreach (fns[k]) begin
         Funct = fns[k];
         push("DECODE"); push("EXECUTE"); push("ALUWB"); push("FETCH");
         while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk); reset = (e.st == "RESET"); #1;
            n_chk++;
            if (observe() !== e.v) begin
               n_fail++;
               $display("FAIL rtype fn=%b %s: got %h want %h", Funct, e.st, observe(), e.v);
            end
            n_chk++;
            if (instr_count !== e.c) begin
               n_fail++;
               $display("FAIL rtype %s count: got %0d want %0d", e.st, instr_count, e.c);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      Op = 6'b100011;
      push("DECODE"); push("MEMADR"); push("RESET");
      push("FETCH"); push("DECODE"); push("MEMADR");
      push("MEMRD"); push("MEMWB"); push("FETCH");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); reset = (e.st == "RESET"); #1;
         n_chk++;
         if (observe() !== e.v) begin
            n_fail++;
            $display("FAIL reset_mid %s: got %h want %h", e.st, observe(), e.v);
         end
         n_chk++;
         if (instr_count !== e.c) begin
            n_fail++;
            $display("FAIL reset_mid %s count: got %0d want %0d", e.st, instr_count, e.c);
         end
      end
   endtask

   task automatic test_illegal();
      exp_t e;
      Op = 6'b111111;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      push("DECODE");
      for (int i = 0; i < 10; i++) push("HALT");
      push("RESET");
`else
      push("NOP_DECODE");
`endif
      push("FETCH");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); reset = (e.st == "RESET"); #1;
         n_chk++;
         if (observe() !== e.v) begin
            n_fail++;
            $display("FAIL illegal %s: got %h want %h", e.st, observe(), e.v);
         end
         n_chk++;
         if (instr_count !== e.c) begin
            n_fail++;
            $display("FAIL illegal %s count: got %0d want %0d", e.st, instr_count, e.c);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      Op = 6'b001000;
      push("RESET");
      for (int i = 0; i < 4; i++) begin
         push("FETCH"); push("DECODE"); push("ADDIEX"); push("ADDIWB");
      end
      push("FETCH");
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); reset = (e.st == "RESET"); #1;
         n_chk++;
         if (observe() !== e.v) begin
            n_fail++;
            $display("FAIL addi %s: got %h want %h", e.st, observe(), e.v);
         end
         n_chk++;
         if (instr_count !== e.c) begin
            n_fail++;
            $display("FAIL addi %s count: got %0d want %0d", e.st, instr_count, e.c);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_beq();
      test_rtype();
      test_reset_mid();
      test_illegal();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
